// File: rtl/bof_guard_ctrl.sv
// bof_guard_ctrl: sequencing controller for the heap-overflow detector.
// It arms and disarms crash detection, runs timed range-buffer flushes, and
// correlates "load from tracked overflow range" with committed JALRs.
// Optional build macro: BOF_CTRL_AUTOFLUSH_EN -- when defined, an acknowledged
// alert flushes the range buffer before re-arming.
module bof_guard_ctrl #(
  parameter int FLUSH_CYCLES = 4,
  parameter int WINDOW       = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic             load_in_range_i,
  input  logic             jalr_commit_i,
  input  logic [31:0]      jalr_pc_i,
  output logic             en_crash_o,
  output logic             rst_buf_o,
  output logic             crash_req_o,
  input  logic             crash_ack_i,
  output logic [31:0]      crash_pc_o,
  output logic [CNT_W-1:0] event_count_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FLUSH = 2'd2,
    S_ALERT = 2'd3
  } state_e;

  localparam logic [1:0] OP_ENABLE  = 2'd1;
  localparam logic [1:0] OP_DISABLE = 2'd2;
  localparam logic [1:0] OP_FLUSH   = 2'd3;

  // Flush counter counts down from FLUSH_CYCLES-1 to 0 while in FLUSH.
  localparam int            FW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [3:0]    WIN_LD     = 4'(WINDOW);

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [3:0]        win_q, win_d;
  logic [31:0]       pc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              en_q, rb_q, req_q;
  logic              trigger;
  logic              cmd_go;

  // A JALR while armed triggers if the load flag is up now or was up recently.
  assign trigger     = (state_q == S_ARMED) && jalr_commit_i &&
                       (load_in_range_i || (win_q != 4'd0));
  // A trigger steals the cycle, so a coincident command stays pending.
  assign cmd_ready_o = (state_q == S_IDLE) || ((state_q == S_ARMED) && !trigger);
  assign cmd_go      = cmd_valid_i && cmd_ready_o;

  // Next-state, return-target, flush-count and window-count logic.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    fcnt_d  = fcnt_q;
    win_d   = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (cmd_go && cmd_op_i == OP_ENABLE) begin
          state_d = S_ARMED;
        end else if (cmd_go && cmd_op_i == OP_FLUSH) begin
          state_d = S_FLUSH;
          ret_d   = S_IDLE;
          fcnt_d  = FLUSH_LAST;
        end
      end
      S_ARMED: begin
        if (load_in_range_i) begin
          win_d = WIN_LD;
        end else if (win_q != 4'd0) begin
          win_d = win_q - 4'd1;
        end
        if (trigger) begin
          state_d = S_ALERT;
        end else if (cmd_go && cmd_op_i == OP_DISABLE) begin
          state_d = S_IDLE;
        end else if (cmd_go && cmd_op_i == OP_FLUSH) begin
          state_d = S_FLUSH;
          ret_d   = S_ARMED;
          fcnt_d  = FLUSH_LAST;
        end
      end
      S_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = ret_q;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      S_ALERT: begin
        if (crash_ack_i) begin
`ifdef BOF_CTRL_AUTOFLUSH_EN
          state_d = S_FLUSH;
          ret_d   = S_ARMED;
          fcnt_d  = FLUSH_LAST;
`else
          state_d = S_ARMED;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      fcnt_q  <= '0;
      win_q   <= 4'd0;
      pc_q    <= 32'd0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rb_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      fcnt_q  <= fcnt_d;
      win_q   <= win_d;
      en_q    <= (state_d == S_ARMED);
      rb_q    <= (state_d == S_FLUSH);
      req_q   <= (state_d == S_ALERT);
      if (trigger) begin
        pc_q <= jalr_pc_i;
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign en_crash_o    = en_q;
  assign rst_buf_o     = rb_q;
  assign crash_req_o   = req_q;
  assign crash_pc_o    = pc_q;
  assign event_count_o = cnt_q;
  assign state_o       = state_q;

endmodule
